// File: rtl/fetch_mul_share_arb_if.sv
// rtl/fetch_mul_share_arb_if.sv - request/response bundle for the shared fetch multiplier
interface fetch_mul_share_arb_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [16*N_REQ-1:0] req_a;
  logic [16*N_REQ-1:0] req_b;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [27:0]         rsp_p;
  logic [ID_W-1:0]     rsp_id;
  logic                busy;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_p, rsp_id, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_p, rsp_id, busy
  );
endinterface

// File: rtl/fetch_mul_share_arb.sv
// rtl/fetch_mul_share_arb.sv - round-robin shared 16x16->28 multiplier with credit-gated output FIFO
module fetch_mul_share_arb #(
  parameter int N_REQ      = 4,
  parameter int MUL_STAGES = 1,
  parameter int OUT_DEPTH  = 4,
  parameter int ID_W       = 2
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  fetch_mul_share_arb_if.slave bus
);
  localparam int CW = $clog2(OUT_DEPTH + MUL_STAGES + 1);
  localparam int AW = $clog2(OUT_DEPTH);

  // Reset asserts asynchronously, releases two clocks later in step with ap_clk.
  logic [1:0] rst_sync;
  logic       rst_n_i;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) rst_sync <= 2'b00;
    else           rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n_i = rst_sync[1];

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] gnt;
  logic            found;
  logic [ID_W:0]   cand;
  logic [CW-1:0]   count;
  logic [CW-1:0]   inflight;
  logic            issue_ok;
  logic            hs;

  always_comb begin
    found = 1'b0;
    gnt   = '0;
    cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, ptr} + (ID_W+1)'(i);
      if (cand >= (ID_W+1)'(N_REQ)) cand = cand - (ID_W+1)'(N_REQ);
      if (!found && bus.req_valid[cand[ID_W-1:0]]) begin
        found = 1'b1;
        gnt   = cand[ID_W-1:0];
      end
    end
  end

  // Everything issued but not yet popped holds a FIFO slot, so the pipeline never stalls.
  assign issue_ok      = (count + inflight) < CW'(OUT_DEPTH);
  assign hs            = rst_n_i & found & issue_ok;
  assign bus.req_ready = hs ? (N_REQ'(1) << gnt) : '0;

  logic            v_q;
  logic [15:0]     a_q;
  logic [15:0]     b_q;
  logic [ID_W-1:0] id_q;
  logic [27:0]     prod;

  always_ff @(posedge ap_clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      v_q  <= 1'b0;
      a_q  <= '0;
      b_q  <= '0;
      id_q <= '0;
      ptr  <= '0;
    end else begin
      v_q <= hs;
      if (hs) begin
        a_q  <= bus.req_a[16*gnt +: 16];
        b_q  <= bus.req_b[16*gnt +: 16];
        id_q <= gnt;
        ptr  <= (gnt == ID_W'(N_REQ-1)) ? '0 : gnt + ID_W'(1);
      end
    end
  end

  assign prod = 28'(a_q) * 28'(b_q);

  logic            out_v;
  logic [27:0]     out_p;
  logic [ID_W-1:0] out_id;
  logic            pipe_busy;

  generate
    if (MUL_STAGES == 1) begin : g_direct
      assign out_v     = v_q;
      assign out_p     = prod;
      assign out_id    = id_q;
      assign inflight  = CW'(v_q);
      assign pipe_busy = v_q;
    end else begin : g_pipe
      localparam int D = MUL_STAGES - 1;
      logic [D-1:0]    dv;
      logic [27:0]     dp  [D];
      logic [ID_W-1:0] did [D];

      always_ff @(posedge ap_clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
          dv <= '0;
          for (int k = 0; k < D; k++) begin
            dp[k]  <= '0;
            did[k] <= '0;
          end
        end else begin
          dv <= D'({dv, v_q});
          dp[0]  <= prod;
          did[0] <= id_q;
          for (int k = 1; k < D; k++) begin
            dp[k]  <= dp[k-1];
            did[k] <= did[k-1];
          end
        end
      end

      always_comb begin
        inflight = CW'(v_q);
        for (int k = 0; k < D; k++) inflight = inflight + CW'(dv[k]);
      end

      assign out_v     = dv[D-1];
      assign out_p     = dp[D-1];
      assign out_id    = did[D-1];
      assign pipe_busy = v_q | (|dv);
    end
  endgenerate

  logic [27:0]     mem_p  [OUT_DEPTH];
  logic [ID_W-1:0] mem_id [OUT_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            pop;

  assign bus.rsp_valid = (count != '0);
  assign pop           = bus.rsp_valid & bus.rsp_ready;

  // Storage is cleared on reset so the head reads zero before the first push.
  always_ff @(posedge ap_clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int k = 0; k < OUT_DEPTH; k++) begin
        mem_p[k]  <= '0;
        mem_id[k] <= '0;
      end
    end else begin
      if (out_v) begin
        mem_p[wr_ptr]  <= out_p;
        mem_id[wr_ptr] <= out_id;
        wr_ptr <= (wr_ptr == AW'(OUT_DEPTH-1)) ? '0 : wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= (rd_ptr == AW'(OUT_DEPTH-1)) ? '0 : rd_ptr + AW'(1);
      if (out_v && !pop)      count <= count + CW'(1);
      else if (!out_v && pop) count <= count - CW'(1);
    end
  end

  assign bus.rsp_p  = mem_p[rd_ptr];
  assign bus.rsp_id = mem_id[rd_ptr];
  assign bus.busy   = pipe_busy | (count != '0);
endmodule

// File: tb/tb_fetch_mul_share_arb.sv
// tb/tb_fetch_mul_share_arb.sv - directed and random checks of fetch_mul_share_arb against a queue model
module tb_fetch_mul_share_arb;
  localparam int N   = 4;
  localparam int MS  = 1;
  localparam int OD  = 4;
  localparam int IDW = 2;

  logic ap_clk   = 1'b0;
  logic ap_rst_n = 1'b0;
  always #5 ap_clk = ~ap_clk;

  fetch_mul_share_arb_if #(.N_REQ(N), .ID_W(IDW)) bus ();

  fetch_mul_share_arb #(
    .N_REQ(N), .MUL_STAGES(MS), .OUT_DEPTH(OD), .ID_W(IDW)
  ) dut (
    .ap_clk  (ap_clk),
    .ap_rst_n(ap_rst_n),
    .bus     (bus)
  );

  typedef struct {
    int     id;
    longint p;
    int     cyc;
  } item_t;

  item_t       q[$];
  int          grants[$];
  int          errors = 0;
  int          checks = 0;
  int          mptr   = 0;
  int          cyc    = 0;
  logic [N-1:0] vld;
  logic [15:0] a_in [N];
  logic [15:0] b_in [N];
  logic        rdy;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus.req_valid = vld;
    for (int i = 0; i < N; i++) begin
      bus.req_a[16*i +: 16] = a_in[i];
      bus.req_b[16*i +: 16] = b_in[i];
    end
    bus.rsp_ready = rdy;
  endtask

  // Model: every issued-but-unpopped product owns one slot; each appears MS+1 cycles after issue.
  task automatic tick();
    int          g;
    bit          found;
    bit          ev;
    logic [N-1:0] er;
    item_t       it;
    drive();
    @(negedge ap_clk);
    found = 1'b0;
    g     = 0;
    for (int k = 0; k < N; k++) begin
      if (!found && vld[(mptr + k) % N]) begin
        found = 1'b1;
        g     = (mptr + k) % N;
      end
    end
    er = (found && q.size() < OD) ? (N'(1) << g) : '0;
    chk("req_ready", bus.req_ready, er);
    chk("busy", bus.busy, q.size() != 0);
    ev = (q.size() > 0) && (q[0].cyc + MS + 1 <= cyc);
    chk("rsp_valid", bus.rsp_valid, ev);
    if (ev) begin
      chk("rsp_p", bus.rsp_p, q[0].p);
      chk("rsp_id", bus.rsp_id, q[0].id);
      if (rdy) void'(q.pop_front());
    end
    if (er != '0) begin
      it.id  = g;
      it.p   = (longint'(a_in[g]) * longint'(b_in[g])) % (longint'(1) << 28);
      it.cyc = cyc;
      q.push_back(it);
      grants.push_back(g);
      mptr = (g + 1) % N;
    end
    @(posedge ap_clk);
    #1;
    cyc++;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      a_in[i] = 16'($urandom);
      b_in[i] = 16'($urandom);
    end
  endtask

  initial begin
    int     n0;
    int     n1;
    int     seen;
    longint exp_p;

    vld = '0;
    rdy = 1'b1;
    for (int i = 0; i < N; i++) begin
      a_in[i] = '0;
      b_in[i] = '0;
    end
    drive();
    #22;
    vld = '1;
    drive();
    #1;
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_p", bus.rsp_p, 0);
    chk("rst_rsp_id", bus.rsp_id, 0);
    chk("rst_busy", bus.busy, 0);
    vld = '0;
    @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    repeat (3) tick();

    a_in[0] = 16'd1000;
    b_in[0] = 16'd200;
    vld = 4'b0001;
    tick();
    vld = '0;
    chk("t1_busy_c1", bus.busy, 1);
    chk("t1_valid_c1", bus.rsp_valid, 0);
    tick();
    chk("t1_valid_c2", bus.rsp_valid, 1);
    chk("t1_prod", bus.rsp_p, 200000);
    chk("t1_id", bus.rsp_id, 0);
    chk("t1_busy_c2", bus.busy, 1);
    tick();
    chk("t1_busy_c3", bus.busy, 0);
    tick();

    n0 = grants.size();
    vld = '1;
    repeat (12) begin
      rand_ops();
      tick();
    end
    chk("t2_grant_count", grants.size() - n0, 12);
    for (int k = n0 + 1; k < grants.size(); k++)
      chk("t2_rr_order", grants[k], (grants[k-1] + 1) % N);
    vld = '0;
    repeat (4) tick();

    a_in[2] = 16'hFFFF;
    b_in[2] = 16'hFFFF;
    vld = 4'b0100;
    tick();
    vld = '0;
    tick();
    chk("t3_trunc", bus.rsp_p, 28'hFFE0001);
    chk("t3_id", bus.rsp_id, 2);
    repeat (2) tick();

    n0 = grants.size();
    rand_ops();
    vld = 4'b1100;
    repeat (2) tick();
    chk("t5_first_grant", grants[n0], 3);
    chk("t5_second_grant", grants[n0+1], 2);
    vld = 4'b1101;
    repeat (N) tick();
    seen = 0;
    for (int k = n0 + 2; k < n0 + 2 + N && k < grants.size(); k++)
      if (grants[k] == 0) seen = 1;
    chk("t5_req0_served", seen, 1);
    vld = '0;
    repeat (4) tick();

    rdy = 1'b0;
    vld = 4'b0010;
    n0 = grants.size();
    repeat (8) begin
      rand_ops();
      tick();
    end
    chk("t4_handshakes", grants.size() - n0, OD);
    chk("t4_ready_off", bus.req_ready, 0);
    rdy = 1'b1;
    n1 = grants.size();
    tick();
    chk("t4_no_issue_on_pop", grants.size() - n1, 0);
    tick();
    chk("t4_issue_after_pop", grants.size() - n1, 1);
    repeat (8) tick();
    vld = '0;
    repeat (6) tick();

    rdy = 1'b0;
    vld = 4'b0010;
    repeat (3) begin
      rand_ops();
      tick();
    end
    vld = '0;
    chk("t6_busy_before", bus.busy, 1);
    ap_rst_n = 1'b0;
    vld = '1;
    drive();
    #1;
    chk("t6_rst_req_ready", bus.req_ready, 0);
    chk("t6_rst_rsp_valid", bus.rsp_valid, 0);
    chk("t6_rst_rsp_p", bus.rsp_p, 0);
    chk("t6_rst_rsp_id", bus.rsp_id, 0);
    chk("t6_rst_busy", bus.busy, 0);
    vld = '0;
    q.delete();
    mptr = 0;
    rdy = 1'b1;
    repeat (2) tick();
    ap_rst_n = 1'b1;
    repeat (4) tick();
    rand_ops();
    exp_p = (longint'(a_in[3]) * longint'(b_in[3])) % (longint'(1) << 28);
    vld = 4'b1000;
    tick();
    vld = '0;
    tick();
    chk("t6_after_valid", bus.rsp_valid, 1);
    chk("t6_after_p", bus.rsp_p, exp_p);
    chk("t6_after_id", bus.rsp_id, 3);
    repeat (2) tick();

    repeat (300) begin
      vld = N'($urandom);
      rand_ops();
      rdy = ($urandom_range(0, 3) != 0);
      tick();
    end
    vld = '0;
    rdy = 1'b1;
    repeat (12) tick();
    chk("drain_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
